// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Owner codes double as bit positions in the request/grant vectors.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;

  // Keeps a latency/limit parameter inside the 1..15 range a CNT_W counter can hold.
  function automatic logic [CNT_W-1:0] clamp_cnt(input int val);
    if (val < 1)
      return CNT_W'(1);
    else if (val > 15)
      return CNT_W'(15);
    else
      return CNT_W'(val);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: one prioritised requester, bounded by a
// starvation limit, then the remaining requesters lowest index first.
module mem_arb_pick #(
  parameter int N_REQ      = 2,
  parameter int PRI_IDX    = 1,
  parameter int CNT_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic [N_REQ-1:0] grant_o
);

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] rest;
  logic             pri_win;

  assign elig = req_i & ~mask_i;

  always_comb begin
    rest          = elig;
    rest[PRI_IDX] = 1'b0;
  end

  // The priority port yields only once others have waited STARVE_MAX grants.
  assign pri_win = elig[PRI_IDX] &&
                   ((rest == '0) || (starve_cnt_i < CNT_W'(STARVE_MAX)));

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      if (gi == PRI_IDX) begin : g_pri
        assign grant_o[gi] = pri_win;
      end else begin : g_rest
        logic [N_REQ-1:0] below;
        assign below       = (N_REQ'(1) << gi) - N_REQ'(1);
        assign grant_o[gi] = rest[gi] && !pri_win && ((rest & below) == '0);
      end
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and the
// data port with req/ack handshakes; data has priority, fetch delay is bounded.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_INIT   = clamp_cnt(MEM_LAT);
  localparam logic [CNT_W-1:0] STARVE_LIM = clamp_cnt(STARVE_MAX);

  arb_state_e          state_q;
  owner_e              owner_q;
  logic                we_q;
  logic [CNT_W-1:0]    lat_cnt_q;
  logic [CNT_W-1:0]    starve_q;
  logic [CNT_W-1:0]    starve_d;

  logic                if_ack_q;
  logic                d_ack_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                mem_en_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [1:0]          mem_size_q;
  logic                mem_signed_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [NUM_REQ-1:0]  req_vec;
  logic [NUM_REQ-1:0]  mask_vec;
  logic [NUM_REQ-1:0]  grant_vec;
  logic                if_pend;

  always_comb begin
    req_vec         = '0;
    req_vec[OWN_IF] = if_req;
    req_vec[OWN_D]  = d_req;
  end

  // In RESP the port just served is hidden so the other side gets a turn.
  always_comb begin
    mask_vec = '0;
    if (state_q == ST_RESP)
      mask_vec[owner_q] = 1'b1;
  end

  mem_arb_pick #(
    .N_REQ      (NUM_REQ),
    .PRI_IDX    (int'(OWN_D)),
    .CNT_W      (CNT_W),
    .STARVE_MAX (int'(STARVE_LIM))
  ) u_pick (
    .req_i        (req_vec),
    .mask_i       (mask_vec),
    .starve_cnt_i (starve_q),
    .grant_o      (grant_vec)
  );

  assign if_pend = if_req & ~mask_vec[OWN_IF];

  always_comb begin
    starve_d = starve_q;
    if (!if_pend || grant_vec[OWN_IF])
      starve_d = '0;
    else if (grant_vec[OWN_D] && (starve_q < STARVE_LIM))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      lat_cnt_q    <= '0;
      starve_q     <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_size_q   <= '0;
      mem_signed_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_size_q   <= '0;
      mem_signed_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;

      case (state_q)
        ST_IDLE, ST_RESP: begin
          starve_q <= starve_d;
          // Request fields land directly in the mem_* registers shown in ISSUE.
          if (grant_vec[OWN_D]) begin
            state_q      <= ST_ISSUE;
            owner_q      <= OWN_D;
            we_q         <= d_we;
            mem_en_q     <= 1'b1;
            mem_read_q   <= ~d_we;
            mem_write_q  <= d_we;
            mem_size_q   <= d_size;
            mem_signed_q <= d_signed;
            mem_addr_q   <= d_addr;
            mem_wdata_q  <= d_wdata;
          end else if (grant_vec[OWN_IF]) begin
            state_q      <= ST_ISSUE;
            owner_q      <= OWN_IF;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b1;
            mem_read_q   <= 1'b1;
            mem_size_q   <= SZ_WORD;
            mem_addr_q   <= if_addr;
          end else begin
            state_q      <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          lat_cnt_q <= LAT_INIT;
          state_q   <= ST_WAIT;
        end

        ST_WAIT: begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
          if (lat_cnt_q <= CNT_W'(1)) begin
            state_q <= ST_RESP;
            if (owner_q == OWN_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end else begin
              d_ack_q <= 1'b1;
              if (!we_q)
                d_rdata_q <= mem_rdata;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ack     = if_ack_q;
  assign d_ack      = d_ack_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_size   = mem_size_q;
  assign mem_signed = mem_signed_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  assign stall_if   = if_req & ~if_ack_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised fetch/data requesters against a timestamp-based arbitration model;
// a negedge monitor checks memory strobes, acks and held read data.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int N_CYC      = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_signed;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_signed(mem_signed), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          own_d;
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        mem_q[$];
  exp_t        ack_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] held_if = '0;
  logic [31:0] held_d  = '0;

  // Requester and model state
  bit if_act, if_drop, if_gnt, d_act, d_drop, d_gnt;
  bit if_ack_seen, d_ack_seen, no_new;
  bit m_busy, m_own_d;
  int m_resp, m_idx, starve, n_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  function automatic logic [31:0] mem_data(input int idx, input logic [7:0] a);
    return (32'h9E3779B9 * 32'(idx + 1)) ^ {a, 24'h5A5A5A};
  endfunction

  // Memory: data is valid only in the cycle exactly MEM_LAT after mem_en.
  initial begin
    int          idx = 0;
    int          iss = -100;
    logic [31:0] dat = '0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en === 1'b1) begin
        iss = cyc;
        dat = mem_data(idx, mem_addr);
        idx++;
      end
      mem_rdata = (cyc == iss + MEM_LAT) ? dat : $urandom;
    end
  end

  // Reference: arbitration points are idle cycles and the ack cycle of the
  // current access; each grant fixes mem_en at +1 and the ack at +MEM_LAT+2.
  task automatic model_arb();
    bit   at_resp, ir, dr, gd, gf;
    exp_t e;
    at_resp = m_busy && (cyc == m_resp);
    if (m_busy && !at_resp) return;
    ir = if_req && !(at_resp && !m_own_d);
    dr = d_req && !(at_resp && m_own_d);
    gd = dr && (!ir || starve < STARVE_MAX);
    gf = ir && !gd;
    if (!ir || gf) starve = 0;
    else if (gd && starve < STARVE_MAX) starve++;
    if (gd || gf) begin
      e.cyc   = cyc + 1;
      e.own_d = gd;
      e.we    = gd ? d_we : 1'b0;
      e.size  = d_size;
      e.sgn   = d_signed;
      e.addr  = gd ? d_addr : if_addr;
      e.wdata = d_wdata;
      e.rdata = mem_data(m_idx, e.addr);
      m_idx++;
      mem_q.push_back(e);
      e.cyc   = cyc + MEM_LAT + 2;
      ack_q.push_back(e);
      m_busy  = 1'b1;
      m_resp  = e.cyc;
      m_own_d = gd;
      if (gd) d_gnt = 1'b1;
      else    if_gnt = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic drive_reqs();
    if (if_ack_seen) if_act = 1'b0;
    if (d_ack_seen)  d_act  = 1'b0;
    if (!if_act && !no_new && $urandom_range(0, 9) < 6) begin
      if_act = 1'b1; if_drop = 1'b0; if_gnt = 1'b0;
      if_addr = 8'($urandom);
    end else if (if_act && !if_gnt && !no_new && $urandom_range(0, 31) == 0) begin
      if_act = 1'b0;
    end else if (if_act && if_gnt && $urandom_range(0, 15) == 0) begin
      if_drop = 1'b1;
    end
    if (!d_act && !no_new && $urandom_range(0, 9) < 5) begin
      d_act = 1'b1; d_drop = 1'b0; d_gnt = 1'b0;
      d_we     = 1'($urandom_range(0, 1));
      d_size   = 2'($urandom_range(0, 2));
      d_signed = 1'($urandom_range(0, 1));
      d_addr   = 8'($urandom);
      d_wdata  = $urandom;
    end else if (d_act && !d_gnt && !no_new && $urandom_range(0, 31) == 0) begin
      d_act = 1'b0;
    end else if (d_act && d_gnt && $urandom_range(0, 15) == 0) begin
      d_drop = 1'b1;
    end
    if_req      = if_act && !if_drop;
    d_req       = d_act && !d_drop;
    if_ack_seen = if_ack;
    d_ack_seen  = d_ack;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {if_ack, d_ack, mem_en, mem_read, mem_write, mem_size, mem_signed,
               mem_addr, busy}, '0);
    chk({name, "_rdata"}, {if_rdata, d_rdata}, '0);
    chk({name, "_wdata"}, mem_wdata, '0);
    chk({name, "_stall"}, stall_if, if_req);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("stall_if", stall_if, if_req & ~if_ack);
      if (mem_en === 1'b1) begin
        if (mem_q.size() == 0) begin
          flag("mem_en_unexpected");
        end else begin
          e = mem_q.pop_front();
          chk("mem_cycle", cyc, e.cyc);
          chk("mem_read", mem_read, !e.we);
          chk("mem_write", mem_write, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.own_d) chk("mem_size_signed", {mem_size, mem_signed}, {e.size, e.sgn});
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end else begin
        chk("mem_idle_zero", {mem_read, mem_write, mem_size, mem_signed, mem_addr, mem_wdata}, '0);
        if (mem_q.size() > 0 && mem_q[0].cyc <= cyc) begin
          flag("mem_en_missing");
          void'(mem_q.pop_front());
        end
      end
      if (if_ack || d_ack) begin
        chk("ack_onehot", if_ack & d_ack, 1'b0);
        if (ack_q.size() == 0) begin
          flag("ack_unexpected");
        end else begin
          e = ack_q.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_owner", d_ack, e.own_d);
          if (!e.own_d)    held_if = e.rdata;
          else if (!e.we)  held_d  = e.rdata;
          $display("[TB] cyc=%0d ack %s we=%0d addr=%0h rdata=%0h",
                   cyc, e.own_d ? "D " : "IF", e.we, e.addr, e.rdata);
        end
      end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
        flag("ack_missing");
        void'(ack_q.pop_front());
      end
      chk("if_rdata", if_rdata, held_if);
      chk("d_rdata", d_rdata, held_d);
    end
  end

  // Stimulus and model
  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;
    chk_reset_outputs("reset_state");
    @(posedge clk); #1;
    if_act = 1'b1; if_addr = 8'h00; if_req = 1'b1;
    #2 rst = 1'b0;
    model_arb();

    for (int n = 0; n < N_CYC; n++) begin
      @(posedge clk); #1;
      chk("busy", busy, m_busy);
      drive_reqs();
      if (m_busy && cyc == m_resp - 1 && n_rst < 4 && $urandom_range(0, 9) == 0) begin
        n_rst++;
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        mem_q.delete();
        ack_q.delete();
        held_if = '0; held_d = '0;
        m_busy = 1'b0; starve = 0;
        if_gnt = 1'b0; d_gnt = 1'b0;
        if (if_drop) if_act = 1'b0;
        if (d_drop)  d_act  = 1'b0;
        @(posedge clk); #1;
        drive_reqs();
        #2 rst = 1'b0;
      end
      model_arb();
    end

    no_new = 1'b1;
    for (int k = 0; k < 200 && (ack_q.size() > 0 || if_act || d_act); k++) begin
      @(posedge clk); #1;
      chk("busy", busy, m_busy);
      drive_reqs();
      model_arb();
    end
    if (ack_q.size() > 0 || if_act || d_act) flag("drain_timeout");
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
